bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq.sv | 147 ++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3). A conversion takes
// WIDTH shift cycles plus one DONE cycle; the result is held until the next one.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [WIDTH-1:0]             bin,
  output logic                         busy,
  output logic                         done,
  output logic [4*DIGITS-1:0]          bcd,
  output logic [$clog2(DIGITS+1)-1:0]  ndigits
);

  localparam int BW  = 4 * DIGITS;
  localparam int SW  = BW + WIDTH;
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int NDW = $clog2(DIGITS + 1);

  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("bin_to_bcd_seq: WIDTH must be in 4..32");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [NDW-1:0]   nd_q, nd_d;

  logic [SW-1:0]    adj;
  logic [SW-1:0]    shifted;
  logic [NDW-1:0]   nd_calc;
  logic             last_shift;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign last_shift = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));

  // FSM: next-state logic
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      IDLE:    busy = 1'b0;
      SHIFT:   busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: add-3 correction on every BCD field, then shift left by one.
  // ---------------------------------------------------------------------------
  always_comb begin
    adj = sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_q[WIDTH + 4*i +: 4] >= 4'd5)
        adj[WIDTH + 4*i +: 4] = sr_q[WIDTH + 4*i +: 4] + 4'd3;
    end
    shifted = {adj[SW-2:0], 1'b0};
  end

  // Highest non-zero digit wins; a zero result still reports one digit.
  always_comb begin
    nd_calc = NDW'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (shifted[WIDTH + 4*i +: 4] != 4'd0)
        nd_calc = NDW'(i + 1);
    end
  end

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    bcd_d = bcd_q;
    nd_d  = nd_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d  = {{BW{1'b0}}, bin};
          cnt_d = '0;
        end
      end
      SHIFT: begin
        sr_d  = shifted;
        cnt_d = cnt_q + 1'b1;
        if (last_shift) begin
          bcd_d = shifted[SW-1 -: BW];
          nd_d  = nd_calc;
        end
      end
      default: ;
    endcase
  end

  // An aborted conversion must leave a zero result, so the result registers
  // are cleared along with the working registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
      bcd_q <= '0;
      nd_q  <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      bcd_q <= bcd_d;
      nd_q  <= nd_d;
    end
  end

  assign bcd     = bcd_q;
  assign ndigits = nd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: an 8-bit and a 16-bit instance, checked every cycle
// against a decimal-arithmetic model plus directed literal expectations.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start16;
  logic [7:0]  bin8;
  logic [15:0] bin16;
  logic        busy8, done8, busy16, done16;
  logic [11:0] bcd8;
  logic [19:0] bcd16;
  logic [1:0]  nd8;
  logic [2:0]  nd16;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done8 = 0;
  int n_done16 = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .bin(bin8),
    .busy(busy8), .done(done8), .bcd(bcd8), .ndigits(nd8)
  );

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .bin(bin16),
    .busy(busy16), .done(done16), .bcd(bcd16), .ndigits(nd16)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] to_bcd(input int unsigned v, input int nd);
    logic [63:0] r = '0;
    for (int d = 0; d < nd; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int ndig(input int unsigned v);
    int n = 0;
    if (v == 0) return 1;
    while (v > 0) begin
      n++;
      v = v / 10;
    end
    return n;
  endfunction

  // Model: phase = cycles since the accepted start (-1 when idle); the result
  // appears once phase reaches WIDTH and lasts one cycle there.
  int          m8_ph = -1, m16_ph = -1;
  int unsigned m8_val, m16_val;
  logic [63:0] m8_bcd = '0, m16_bcd = '0;
  int          m8_nd = 0, m16_nd = 0;

  always @(posedge clk) begin
    if (rst) begin
      m8_ph <= -1; m8_bcd <= '0; m8_nd <= 0;
    end else if (m8_ph < 0) begin
      if (start8) begin m8_ph <= 0; m8_val <= bin8; end
    end else if (m8_ph < 8) begin
      m8_ph <= m8_ph + 1;
      if (m8_ph == 7) begin m8_bcd <= to_bcd(m8_val, 3); m8_nd <= ndig(m8_val); end
    end else begin
      m8_ph <= -1;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m16_ph <= -1; m16_bcd <= '0; m16_nd <= 0;
    end else if (m16_ph < 0) begin
      if (start16) begin m16_ph <= 0; m16_val <= bin16; end
    end else if (m16_ph < 16) begin
      m16_ph <= m16_ph + 1;
      if (m16_ph == 15) begin m16_bcd <= to_bcd(m16_val, 5); m16_nd <= ndig(m16_val); end
    end else begin
      m16_ph <= -1;
    end
  end

  always @(negedge clk) begin
    if (done8)  n_done8++;
    if (done16) n_done16++;
    if (chk_en) begin
      check("busy8",   busy8,  m8_ph >= 0);
      check("done8",   done8,  m8_ph == 8);
      check("bcd8",    bcd8,   m8_bcd);
      check("nd8",     nd8,    m8_nd);
      check("busy16",  busy16, m16_ph >= 0);
      check("done16",  done16, m16_ph == 16);
      check("bcd16",   bcd16,  m16_bcd);
      check("nd16",    nd16,   m16_nd);
    end
  end

  // One conversion on the chosen instance with literal result and timing checks.
  task automatic conv(input bit wide, input int unsigned v, input logic [19:0] eb,
                      input int en, input string tag);
    int lat = 0;
    int bc  = 0;
    int w   = wide ? 16 : 8;
    @(negedge clk);
    if (wide) begin start16 = 1'b1; bin16 = 16'(v); end
    else      begin start8  = 1'b1; bin8  = 8'(v);  end
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
    bc = int'(wide ? busy16 : busy8);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      bc += int'(wide ? busy16 : busy8);
      if (wide ? done16 : done8) begin lat = k; break; end
    end
    check({tag, "_latency"}, lat, w);
    check({tag, "_busy_cycles"}, bc, w + 1);
    check({tag, "_bcd"}, wide ? bcd16 : bcd8, eb);
    check({tag, "_ndigits"}, wide ? nd16 : nd8, en);
    @(posedge clk); #1;
    check({tag, "_done_low"}, wide ? done16 : done8, 0);
    check({tag, "_busy_low"}, wide ? busy16 : busy8, 0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_hold"}, wide ? bcd16 : bcd8, eb);
  endtask

  initial begin
    int d0;
    bit seen;
    rst = 1'b1; start8 = 1'b0; start16 = 1'b0; bin8 = '0; bin16 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_bcd8",  bcd8,  0);
    check("rst_nd8",   nd8,   0);
    check("rst_bcd16", bcd16, 0);
    chk_en = 1'b1;
    rst = 1'b0;

    conv(0, 255, 20'h00255, 3, "c255");
    conv(0, 0,   20'h00000, 1, "c0");
    conv(0, 9,   20'h00009, 1, "c9");
    conv(0, 10,  20'h00010, 2, "c10");

    // Restart attempt mid-conversion must be ignored.
    d0 = n_done8;
    @(negedge clk); start8 = 1'b1; bin8 = 8'd200;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1; start8 = 1'b1; bin8 = 8'd7;
    repeat (2) @(posedge clk);
    #1; start8 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done8) begin seen = 1'b1; break; end
    end
    check("repulse_done_seen", seen, 1);
    check("repulse_bcd", bcd8, 12'h200);
    check("repulse_nd",  nd8,  3);
    repeat (12) @(posedge clk);
    check("repulse_one_done", n_done8 - d0, 1);

    // Reset during the 4th shift cycle aborts the conversion.
    d0 = n_done8;
    @(negedge clk); start8 = 1'b1; bin8 = 8'd123;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_bcd",  bcd8,  0);
    check("abort_nd",   nd8,   0);
    repeat (12) @(posedge clk);
    check("abort_no_done", n_done8 - d0, 0);
    conv(0, 45, 20'h00045, 2, "c45");

    conv(1, 65535, 20'h65535, 5, "w65535");
    conv(1, 1000,  20'h01000, 4, "w1000");

    // Start held high: one accept every WIDTH+2 cycles, bin stepped in lockstep.
    d0 = n_done8;
    @(negedge clk); start8 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bin8 = 8'(i);
      repeat (10) @(negedge clk);
    end
    start8 = 1'b0;
    repeat (12) @(negedge clk);
    check("stream_done_count", n_done8 - d0, 256);
    check("stream_last_bcd", bcd8, 12'h255);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
